// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto voice slots,
// retriggering held keys, filling free slots first and stealing the oldest when full.
module midi_voice_allocator #(
    parameter int VOICES = 8
) (
    input  logic                  clock_50_000_000,
    input  logic                  reset,
    input  logic                  msg_valid,
    input  logic                  msg_note_on,
    input  logic                  msg_note_off,
    input  logic [6:0]            msg_key,
    input  logic [6:0]            msg_velocity,
    output logic [VOICES-1:0]     voice_active,
    output logic [VOICES*7-1:0]   voice_key,
    output logic [VOICES*7-1:0]   voice_velocity,
    output logic [VOICES-1:0]     voice_trigger,
    output logic [VOICES-1:0]     voice_release,
    output logic                  voice_stolen
);

    localparam int RW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic [VOICES-1:0] active_q;
    logic [VOICES-1:0] trigger_q;
    logic [VOICES-1:0] release_q;
    logic              stolen_q;
    logic [6:0]        key_q   [VOICES];
    logic [6:0]        vel_q   [VOICES];
    logic [RW-1:0]     rank_q  [VOICES];

    logic          is_on;
    logic          is_off;
    logic          hit_found;
    logic          free_found;
    logic [RW-1:0] hit_idx;
    logic [RW-1:0] free_idx;
    logic [RW-1:0] oldest_idx;
    logic [RW-1:0] target;
    logic [RW-1:0] target_rank;

    // A note-on with zero velocity is a note-off by MIDI convention.
    assign is_on  = msg_valid && msg_note_on && !msg_note_off && (msg_velocity != 7'd0);
    assign is_off = msg_valid && (msg_note_on != msg_note_off) && !is_on;

    // Scan downward so the lowest-index match wins for the free-slot search.
    always_comb begin
        hit_found  = 1'b0;
        free_found = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        oldest_idx = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (active_q[v] && key_q[v] == msg_key) begin
                hit_found = 1'b1;
                hit_idx   = RW'(v);
            end
            if (!active_q[v]) begin
                free_found = 1'b1;
                free_idx   = RW'(v);
            end
            if (rank_q[v] == '0) begin
                oldest_idx = RW'(v);
            end
        end
        target      = hit_found ? hit_idx : (free_found ? free_idx : oldest_idx);
        target_rank = rank_q[target];
    end

    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            active_q  <= '0;
            trigger_q <= '0;
            release_q <= '0;
            stolen_q  <= 1'b0;
            for (int v = 0; v < VOICES; v++) begin
                key_q[v]  <= '0;
                vel_q[v]  <= '0;
                rank_q[v] <= RW'(v);
            end
        end else begin
            trigger_q <= '0;
            release_q <= '0;
            stolen_q  <= 1'b0;
            if (is_on) begin
                active_q[target]  <= 1'b1;
                key_q[target]     <= msg_key;
                vel_q[target]     <= msg_velocity;
                trigger_q[target] <= 1'b1;
                stolen_q          <= !hit_found && !free_found;
                // Promotion keeps ranks a permutation: close the gap, move target to newest.
                for (int v = 0; v < VOICES; v++) begin
                    if (RW'(v) == target) begin
                        rank_q[v] <= RW'(VOICES - 1);
                    end else if (rank_q[v] > target_rank) begin
                        rank_q[v] <= rank_q[v] - 1'b1;
                    end
                end
            end else if (is_off && hit_found) begin
                active_q[hit_idx]  <= 1'b0;
                release_q[hit_idx] <= 1'b1;
            end
        end
    end

    assign voice_active  = active_q;
    assign voice_trigger = trigger_q;
    assign voice_release = release_q;
    assign voice_stolen  = stolen_q;

    for (genvar g = 0; g < VOICES; g++) begin : g_pack
        assign voice_key[g*7 +: 7]      = key_q[g];
        assign voice_velocity[g*7 +: 7] = vel_q[g];
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Self-checking bench for midi_voice_allocator: an allocation-order queue model
// checked every cycle, plus hand-computed expectations for the key scenarios.
module tb_midi_voice_allocator;

    localparam int VOICES = 8;

    logic                clock_50_000_000;
    logic                reset;
    logic                msg_valid;
    logic                msg_note_on;
    logic                msg_note_off;
    logic [6:0]          msg_key;
    logic [6:0]          msg_velocity;
    logic [VOICES-1:0]   voice_active;
    logic [VOICES*7-1:0] voice_key;
    logic [VOICES*7-1:0] voice_velocity;
    logic [VOICES-1:0]   voice_trigger;
    logic [VOICES-1:0]   voice_release;
    logic                voice_stolen;

    int checks   = 0;
    int failures = 0;

    midi_voice_allocator #(.VOICES(VOICES)) dut (
        .clock_50_000_000(clock_50_000_000),
        .reset(reset),
        .msg_valid(msg_valid),
        .msg_note_on(msg_note_on),
        .msg_note_off(msg_note_off),
        .msg_key(msg_key),
        .msg_velocity(msg_velocity),
        .voice_active(voice_active),
        .voice_key(voice_key),
        .voice_velocity(voice_velocity),
        .voice_trigger(voice_trigger),
        .voice_release(voice_release),
        .voice_stolen(voice_stolen)
    );

    initial clock_50_000_000 = 1'b0;
    always #10 clock_50_000_000 = ~clock_50_000_000;

    // Reference model: slot contents plus a queue of slots ordered oldest allocation first.
    bit                m_active [VOICES];
    int                m_key    [VOICES];
    int                m_vel    [VOICES];
    int                order    [$];
    logic [VOICES-1:0] e_trig;
    logic [VOICES-1:0] e_rel;
    logic              e_stolen;

    function automatic void modelReset();
        order.delete();
        for (int v = 0; v < VOICES; v++) begin
            m_active[v] = 1'b0;
            m_key[v]    = 0;
            m_vel[v]    = 0;
            order.push_back(v);
        end
        e_trig   = '0;
        e_rel    = '0;
        e_stolen = 1'b0;
    endfunction

    function automatic void modelPromote(int s);
        for (int i = 0; i < order.size(); i++) begin
            if (order[i] == s) begin
                order.delete(i);
                break;
            end
        end
        order.push_back(s);
    endfunction

    function automatic int modelFind(int k);
        for (int v = 0; v < VOICES; v++) begin
            if (m_active[v] && m_key[v] == k) return v;
        end
        return -1;
    endfunction

    always @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            modelReset();
        end else begin
            int hit;
            int s;
            e_trig   = '0;
            e_rel    = '0;
            e_stolen = 1'b0;
            hit = modelFind(int'(msg_key));
            if (msg_valid && msg_note_on && !msg_note_off && msg_velocity != 0) begin
                s = hit;
                if (s < 0) begin
                    for (int v = VOICES - 1; v >= 0; v--) begin
                        if (!m_active[v]) s = v;
                    end
                end
                if (s < 0) begin
                    s        = order[0];
                    e_stolen = 1'b1;
                end
                m_active[s] = 1'b1;
                m_key[s]    = int'(msg_key);
                m_vel[s]    = int'(msg_velocity);
                e_trig[s]   = 1'b1;
                modelPromote(s);
            end else if (msg_valid && (msg_note_on != msg_note_off) && hit >= 0) begin
                m_active[hit] = 1'b0;
                e_rel[hit]    = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, the DUT's registered outputs must match the model.
    always @(posedge clock_50_000_000) begin
        logic [VOICES-1:0]   ea;
        logic [VOICES*7-1:0] ek;
        logic [VOICES*7-1:0] ev;
        #1;
        for (int v = 0; v < VOICES; v++) begin
            ea[v]        = m_active[v];
            ek[v*7 +: 7] = 7'(m_key[v]);
            ev[v*7 +: 7] = 7'(m_vel[v]);
        end
        checkOutput("cyc_active",   voice_active,   ea);
        checkOutput("cyc_key",      voice_key,      ek);
        checkOutput("cyc_velocity", voice_velocity, ev);
        checkOutput("cyc_trigger",  voice_trigger,  e_trig);
        checkOutput("cyc_release",  voice_release,  e_rel);
        checkOutput("cyc_stolen",   voice_stolen,   e_stolen);
    end

    task automatic applyStimulus(input bit valid, input bit on, input bit off, input int key, input int vel);
        @(negedge clock_50_000_000);
        msg_valid    = valid;
        msg_note_on  = on;
        msg_note_off = off;
        msg_key      = 7'(key);
        msg_velocity = 7'(vel);
        @(posedge clock_50_000_000);
        #2;
        msg_valid = 1'b0;
    endtask

    function automatic logic [6:0] slotKey(int v);
        return voice_key[v*7 +: 7];
    endfunction

    function automatic logic [6:0] slotVel(int v);
        return voice_velocity[v*7 +: 7];
    endfunction

    initial begin
        reset        = 1'b1;
        msg_valid    = 1'b0;
        msg_note_on  = 1'b0;
        msg_note_off = 1'b0;
        msg_key      = '0;
        msg_velocity = '0;
        repeat (2) @(posedge clock_50_000_000);
        @(negedge clock_50_000_000);
        reset = 1'b0;
        checkOutput("reset_active", voice_active, 0);
        checkOutput("reset_key", voice_key, 0);

        applyStimulus(1, 1, 0, 10, 80);
        checkOutput("on10_active", voice_active, 8'h01);
        checkOutput("on10_trigger", voice_trigger, 8'h01);
        checkOutput("on10_key", slotKey(0), 10);
        checkOutput("on10_vel", slotVel(0), 80);
        applyStimulus(1, 1, 0, 20, 0);
        checkOutput("on20v0_trigger", voice_trigger, 0);
        checkOutput("on20v0_active", voice_active, 8'h01);
        applyStimulus(1, 0, 1, 10, 0);
        checkOutput("off10_active", voice_active, 0);
        checkOutput("off10_release", voice_release, 8'h01);
        checkOutput("off10_key_kept", slotKey(0), 10);

        for (int k = 60; k < 68; k++) applyStimulus(1, 1, 0, k, 100);
        checkOutput("fill_active", voice_active, 8'hFF);
        checkOutput("fill_key7", slotKey(7), 67);
        applyStimulus(1, 1, 0, 70, 100);
        checkOutput("steal_key0", slotKey(0), 70);
        checkOutput("steal_stolen", voice_stolen, 1'b1);
        checkOutput("steal_trigger", voice_trigger, 8'h01);
        applyStimulus(1, 1, 0, 63, 5);
        checkOutput("retrig_vel3", slotVel(3), 5);
        checkOutput("retrig_trigger", voice_trigger, 8'h08);
        checkOutput("retrig_stolen", voice_stolen, 1'b0);
        applyStimulus(1, 1, 0, 71, 50);
        checkOutput("steal2_trigger", voice_trigger, 8'h02);
        checkOutput("steal2_key1", slotKey(1), 71);

        applyStimulus(1, 0, 0, 62, 40);
        checkOutput("ign_low_trigger", voice_trigger | voice_release, 0);
        applyStimulus(1, 1, 1, 62, 40);
        checkOutput("ign_high_trigger", voice_trigger | voice_release, 0);
        checkOutput("ign_high_key2", slotKey(2), 62);
        applyStimulus(1, 0, 1, 99, 0);
        checkOutput("ign_off99_release", voice_release, 0);
        checkOutput("ign_off99_active", voice_active, 8'hFF);

        for (int k = 1; k <= 4; k++) applyStimulus(1, 1, 0, k, k);
        @(negedge clock_50_000_000);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midreset_active", voice_active, 0);
        checkOutput("midreset_key", voice_key, 0);
        checkOutput("midreset_vel", voice_velocity, 0);
        checkOutput("midreset_pulses", {voice_trigger, voice_release, voice_stolen}, 0);
        @(negedge clock_50_000_000);
        reset = 1'b0;
        applyStimulus(1, 1, 0, 33, 9);
        checkOutput("postreset_trigger", voice_trigger, 8'h01);
        for (int k = 34; k < 41; k++) applyStimulus(1, 1, 0, k, 9);
        applyStimulus(1, 1, 0, 90, 9);
        checkOutput("postreset_steal", voice_trigger, 8'h01);

        for (int i = 0; i < 400; i++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            applyStimulus($urandom_range(0, 7) != 0,
                          kind < 6 || kind == 9,
                          kind >= 6,
                          int'($urandom_range(40, 52)),
                          ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 127)));
        end

        @(negedge clock_50_000_000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

Schedules the synthesizer's polyphonic voice slots among incoming MIDI note events. Sits between the MIDI decoder (via the top-level message unpacking) and the voice/oscillator bank. It assigns each note-on to a voice slot, releases the slot on the matching note-off, and steals the least-recently-allocated slot when all slots are busy. It drives per-voice key, velocity, active state and one-cycle trigger/release pulses that start and stop envelopes.

## Interface
- VOICES, 8: number of voice slots, 2..16.
- clock_50_000_000  input  1  system clock, all state on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- msg_valid  input  1  one-cycle strobe: a decoded message is present on the msg_* fields.
- msg_note_on  input  1  message is NOTE_ON (any channel).
- msg_note_off  input  1  message is NOTE_OFF (any channel).
- msg_key  input  7  MIDI key number, 0..127.
- msg_velocity  input  7  MIDI velocity, 0..127.
- voice_active  output  VOICES  slot v is currently sounding.
- voice_key  output  VOICES×7  key held by slot v.
- voice_velocity  output  VOICES×7  velocity of slot v.
- voice_trigger  output  VOICES  one-cycle pulse: slot v (re)started a note.
- voice_release  output  VOICES  one-cycle pulse: slot v released its note.
- voice_stolen  output  1  one-cycle pulse: the last allocation evicted a sounding note.

## Operation
- Per slot registers: active, key, velocity, rank (log2 VOICES bits). Rank is a strict LRU ordering: 0 = oldest allocation, VOICES-1 = newest; ranks are always a permutation of 0..VOICES-1.
- Message classification on msg_valid:
  - NOTE_ON with velocity > 0 → ON.
  - NOTE_OFF, or NOTE_ON with velocity 0 → OFF.
  - msg_note_on and msg_note_off both high, or both low → ignored; no state change.
- ON handling, in priority order:
  1. Retrigger: an active slot already holds msg_key. Update its velocity, pulse its trigger, and promote it to newest.
  2. Allocate: otherwise take the lowest-index inactive slot. Set active, key and velocity, pulse trigger, promote to newest.
  3. Steal: all slots are active. Take the rank-0 slot, overwrite key and velocity, pulse trigger and voice_stolen, promote to newest. No release pulse is issued for the evicted note.
- Promotion of slot s with old rank r: slots with rank > r decrement by 1, and s becomes VOICES-1. Ranks are never changed except by promotion.
- OFF handling: if an active slot holds msg_key, clear active and pulse its release. Key, velocity and rank are retained. An OFF for a key not held is ignored.
- At most one slot holds a given key while active; retrigger guarantees this.

## Timing
- A message sampled with msg_valid at edge t is applied at edge t. Updated voice_* registers and pulses are visible in the cycle after t.
- Pulses (voice_trigger, voice_release, voice_stolen) are high for exactly one cycle, then return to 0. If msg_valid arrives on consecutive cycles, each cycle's pulses reflect only that cycle's message.
- One message per cycle, no backpressure. Back-to-back messages must be handled at full rate; a message sees the state left by the previous cycle's message.
- Reset values: voice_active = 0, voice_key = 0, voice_velocity = 0, all pulses = 0, rank[v] = v.
- Reset asserted mid-operation clears all state immediately; no release pulses are emitted. The first message after reset deassertion is processed normally.

## Test plan
- Reset, then ON key 10 vel 80 → next cycle: slot 0 active, key 10, vel 80, voice_trigger = 0b0000_0001 for one cycle, rank[0] = 7.
- ON key 20 vel 0, no slot holds 20 → no state change, no pulses. OFF key 10 → slot 0 inactive, voice_release[0] pulses, key 10 retained.
- ON keys 60,61,…,67 vel 100 on consecutive cycles → slots 0..7 active in order. ON key 70 → slot 0 (rank 0) becomes key 70, voice_stolen and voice_trigger[0] pulse, slot 1 becomes rank 0.
- With slot 3 holding key 63, ON key 63 vel 5 → slot 3 velocity 5, trigger[3] pulses, no other slot changes key.
- Ignored inputs → no state change, no pulses:
  - msg_valid with both kind bits low.
  - msg_valid with both kind bits high.
  - OFF for key 99 when no slot holds it.
- Assert reset while 4 slots are active → all outputs 0 in the same cycle, ranks restored to 0..7. Next ON allocates slot 0.
